// File: rtl/sub_pkg.sv
// rtl/sub_pkg.sv - shared types and constants for the word-serial subtract controller
package sub_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Word counter width; never narrower than one bit.
    function automatic int cnt_width(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/sub_seq_ctrl_if.sv
// rtl/sub_seq_ctrl_if.sv - operand/result handshake bundle for sub_seq_ctrl
interface sub_seq_ctrl_if #(
    parameter int WORDS = 4,
    parameter int W     = 16
);
    logic                 in_valid;
    logic                 in_ready;
    logic                 op;
    logic [W*WORDS-1:0]   a;
    logic [W*WORDS-1:0]   b;
    logic                 out_valid;
    logic                 out_ready;
    logic [W*WORDS-1:0]   diff;
    logic                 borrow;
    logic                 zero;

    modport master (
        output in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, diff, borrow, zero
    );

    modport slave (
        input  in_valid, op, a, b, out_ready,
        output in_ready, out_valid, diff, borrow, zero
    );
endinterface

// File: rtl/sub16_bcore.sv
// rtl/sub16_bcore.sv - combinational 16-bit subtract with parallel-prefix borrow
module sub16_bcore
    import sub_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    input  logic              bin,
    output logic [WORD_W-1:0] d,
    output logic              bout
);

    logic [WORD_W-1:0] bor;

    // Kogge-Stone borrow prefix in XOR/AND only: a group that generates never
    // propagates, so the usual OR in G|(P&G') is exclusive and becomes XOR.
    always_comb begin
        logic [WORD_W-1:0] g0, p0, g1, p1, g2, p2, g3, p3, g4;
        p0 = ~(a ^ b);
        g0 = ~a & b;
        g0[0] = g0[0] ^ (p0[0] & bin);
        g1 = g0 ^ (p0 & (g0 << 1));
        p1 = p0 & ~((~p0) << 1);
        g2 = g1 ^ (p1 & (g1 << 2));
        p2 = p1 & ~((~p1) << 2);
        g3 = g2 ^ (p2 & (g2 << 4));
        p3 = p2 & ~((~p2) << 4);
        g4 = g3 ^ (p3 & (g3 << 8));
        bor = g4;
    end

    assign d    = a ^ b ^ {bor[WORD_W-2:0], bin};
    assign bout = bor[WORD_W-1];

endmodule

// File: rtl/sub_seq_ctrl.sv
// rtl/sub_seq_ctrl.sv - word-serial wide subtractor sharing one 16-bit core
module sub_seq_ctrl
    import sub_pkg::*;
#(
    parameter int WORDS = 4,
    parameter int W     = WORD_W
) (
    input  logic           clk,
    input  logic           rst,
    sub_seq_ctrl_if.slave  bus
);

    localparam int CW = cnt_width(WORDS);
    localparam int DW = W * WORDS;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            borrow_q, borrow_d;
    logic            zacc_q, zacc_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   diff_q, diff_d;

    logic [W-1:0]    core_a, core_b, core_d;
    logic            core_bout;

    // Present the current word pair to the shared core.
    always_comb begin
        core_a = a_q[cnt_q*W +: W];
        core_b = b_q[cnt_q*W +: W];
    end

    sub16_bcore u_core (
        .a    (core_a),
        .b    (core_b),
        .bin  (borrow_q),
        .d    (core_d),
        .bout (core_bout)
    );

    // Sequencing: accept in IDLE, one word per cycle in RUN, hold in DONE.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        borrow_d = borrow_q;
        zacc_d   = zacc_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d      = bus.op ? bus.b : bus.a;
                    b_d      = bus.op ? bus.a : bus.b;
                    cnt_d    = '0;
                    borrow_d = 1'b0;
                    zacc_d   = 1'b1;
                    state_d  = RUN;
                end
            end
            RUN: begin
                diff_d[cnt_q*W +: W] = core_d;
                borrow_d = core_bout;
                zacc_d   = zacc_q & (core_d == '0);
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CW'(WORDS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            borrow_q <= 1'b0;
            zacc_q   <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            borrow_q <= borrow_d;
            zacc_q   <= zacc_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.diff      = diff_q;
    assign bus.borrow    = borrow_q;
    assign bus.zero      = zacc_q;

endmodule

// File: tb/tb_sub_seq_ctrl.sv
// tb/tb_sub_seq_ctrl.sv - self-checking bench for sub_seq_ctrl
module tb_sub_seq_ctrl;

    localparam int WORDS = 4;
    localparam int DW    = 16 * WORDS;
    localparam int NV    = 10;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic          op;
        logic [DW-1:0] d;
        logic          bo;
        logic          z;
    } vec_t;

    typedef struct {
        logic [DW-1:0] d;
        logic          bo;
        logic          z;
    } exp_t;

    logic clk;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t tv[NV];

    sub_seq_ctrl_if #(.WORDS(WORDS), .W(16)) bus ();

    sub_seq_ctrl #(.WORDS(WORDS), .W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic o);
        logic [DW:0] r;
        exp_t e;
        r    = o ? ({1'b0, y} - {1'b0, x}) : ({1'b0, x} - {1'b0, y});
        e.d  = r[DW-1:0];
        e.bo = r[DW];
        e.z  = (r[DW-1:0] == '0);
        return e;
    endfunction

    task automatic issue(input logic [DW-1:0] x, input logic [DW-1:0] y, input logic o, input exp_t e);
        @(negedge clk);
        chk("in_ready_before_accept", bus.in_ready, 1);
        bus.a        = x;
        bus.b        = y;
        bus.op       = o;
        bus.in_valid = 1'b1;
        @(posedge clk);
        sb.push_back(e);
        #1 bus.in_valid = 1'b0;
        bus.a = $urandom();
        bus.b = $urandom();
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (n < 20 && bus.out_valid !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("latency", n, WORDS);
    endtask

    task automatic take_result(input string tag);
        exp_t e;
        @(negedge clk);
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s_scoreboard: got empty queue expected one entry", tag);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_out_valid"}, bus.out_valid, 1);
        chk({tag, "_diff"}, bus.diff, e.d);
        chk({tag, "_borrow"}, bus.borrow, e.bo);
        chk({tag, "_zero"}, bus.zero, e.z);
        chk({tag, "_in_ready_done"}, bus.in_ready, 0);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk({tag, "_out_valid_after"}, bus.out_valid, 0);
        chk({tag, "_in_ready_after"}, bus.in_ready, 1);
    endtask

    initial begin
        exp_t e;
        logic [DW-1:0] rx, ry;

        tv[0] = '{64'd5, 64'd3, 1'b0, 64'd2, 1'b0, 1'b0};
        tv[1] = '{64'h0000_0000_0001_0000, 64'd1, 1'b0, 64'h0000_0000_0000_FFFF, 1'b0, 1'b0};
        tv[2] = '{64'd0, 64'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        tv[3] = '{64'd0, 64'd1, 1'b1, 64'd1, 1'b0, 1'b0};
        tv[4] = '{64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D, 1'b0, 64'd0, 1'b0, 1'b1};
        tv[5] = '{64'd1, 64'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0};
        tv[6] = '{64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 64'd1, 1'b0, 1'b0};
        for (int i = 7; i < NV; i++) begin
            rx = {$urandom(), $urandom()};
            ry = {$urandom(), $urandom()};
            e  = model(rx, ry, i[0]);
            tv[i] = '{rx, ry, i[0], e.d, e.bo, e.z};
        end

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.op        = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #1;
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_diff", bus.diff, 0);
        chk("rst_borrow", bus.borrow, 0);
        chk("rst_zero", bus.zero, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            e = '{tv[i].d, tv[i].bo, tv[i].z};
            issue(tv[i].a, tv[i].b, tv[i].op, e);
            wait_valid();
            take_result($sformatf("vec%0d", i));
        end

        // Stall in DONE with a pending request, then release and re-accept.
        issue(64'h20, 64'h10, 1'b0, '{64'h10, 1'b0, 1'b0});
        wait_valid();
        @(negedge clk);
        bus.a        = 64'h100;
        bus.b        = 64'h1;
        bus.op       = 1'b0;
        bus.in_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("hold_out_valid", bus.out_valid, 1);
            chk("hold_in_ready", bus.in_ready, 0);
            chk("hold_diff", bus.diff, 64'h10);
            chk("hold_borrow", bus.borrow, 0);
            chk("hold_zero", bus.zero, 0);
        end
        if (sb.size() > 0) void'(sb.pop_front());
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        chk("release_in_ready", bus.in_ready, 1);
        chk("release_out_valid", bus.out_valid, 0);
        @(posedge clk);
        sb.push_back('{64'hFF, 1'b0, 1'b0});
        #1 bus.in_valid = 1'b0;
        chk("reaccept_in_ready", bus.in_ready, 0);
        wait_valid();
        take_result("reaccept");

        // Asynchronous reset in the middle of RUN discards the operation.
        issue(64'h1234, 64'h1, 1'b0, '{64'h1233, 1'b0, 1'b0});
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("midrst_out_valid", bus.out_valid, 0);
        chk("midrst_in_ready", bus.in_ready, 1);
        chk("midrst_diff", bus.diff, 0);
        chk("midrst_borrow", bus.borrow, 0);
        sb.delete();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            chk("midrst_no_result", bus.out_valid, 0);
        end
        bus.out_ready = 1'b0;
        issue(64'd7, 64'd9, 1'b0, '{64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0});
        wait_valid();
        take_result("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sub_seq_ctrl.md
Name: sub_seq_ctrl

Overview:
- Sequencing controller that runs WORDS*16-bit subtraction on one shared 16-bit borrow-chained subtract core.
- It processes one 16-bit word per cycle, LSW first, and carries the borrow between words in a register.
- It sits between a valid/ready operand producer and a result consumer in the wide-arithmetic layer of the circuit library.
- It trades AND-depth for area: one 16-bit core instead of a full-width subtractor.

Parameters:
- WORDS, 4: number of 16-bit words per operand. Legal range 2..16.
- W, 16: word width. Fixed to 16 and not overridable in practice.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand request.
- in_ready  out  1  controller can accept an operand.
- op  in  1  0: result = a - b; 1: result = b - a. Sampled on accept.
- a  in  W*WORDS  minuend (op=0).
- b  in  W*WORDS  subtrahend (op=0).
- out_valid  out  1  result available.
- out_ready  in  1  consumer takes the result.
- diff  out  W*WORDS  difference, modulo 2^(W*WORDS).
- borrow  out  1  1 when the unsigned minuend < subtrahend.
- zero  out  1  1 when diff == 0.

Behaviour:
- Reset: every register clears immediately on rst=1, independent of clk.
  - State = IDLE, word counter = 0, borrow register = 0, operand registers = 0.
  - Outputs after reset: in_ready=1, out_valid=0, diff=0, borrow=0, zero=0.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1.
  - Accept happens on a clock edge with in_valid=1 (in_ready is 1 in IDLE).
  - On accept, latch the operands, swapping them when op=1.
  - Also on accept: counter=0, borrow_reg=0, zero accumulator=1, state goes to RUN.
- RUN: in_ready=0 and out_valid=0.
  - Each cycle, the core computes word k: {bo, d} = a[k] - b[k] - borrow_reg.
  - Write d into diff word k. Set borrow_reg = bo. Set zero_acc = zero_acc & (d==0).
  - Increment the counter.
  - On the edge that processes k = WORDS-1, state goes to DONE.
- DONE: out_valid=1. diff, borrow (= final borrow_reg) and zero are stable.
  - On the edge with out_ready=1, state goes to IDLE.
- Latency: out_valid rises exactly WORDS edges after the accepting edge. For WORDS=4 that is 4 edges.
- Throughput: one operation per WORDS+2 cycles when out_ready is held high.
- in_ready is high only in IDLE. It is low in DONE even when out_ready=1, so there is no same-cycle re-accept.
- Outputs hold their values after the out_ready handshake, until the next accept overwrites them word by word.
  - Consumers use them only while out_valid=1.
- Inputs a, b and op are ignored outside the accept edge.
- Counter: width clog2(WORDS). It resets to 0 on accept; no wrap occurs within an operation.
- Assert rst mid-RUN or mid-DONE: the operation is discarded, with no partial out_valid.
  - After deassertion: IDLE with in_ready=1.
- in_valid while busy: ignored. The producer must hold its request until in_ready=1.
- Core arithmetic is pure XOR/AND with a ripple-free parallel-prefix borrow, so the core is MPC-friendly.
  - The core contains no clocked logic.

Decomposition:
- Shared package sub_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the constant WORD_W=16;
  - the helper function for counter width.
- One sub-module, sub16_bcore: combinational 16-bit subtract with ports a, b, bin → d, bout.
  - It is built from XOR/AND prefix logic.
- The controller instantiates sub16_bcore exactly once.

Test Plan:
- WORDS=4, op=0, a=5, b=3 → out_valid 4 edges after accept; diff=2, borrow=0, zero=0.
- a=0x0000_0000_0001_0000, b=1 → diff=0x0000_0000_0000_FFFF, borrow=0. Checks borrow propagation across the word-0/word-1 boundary.
- a=0, b=1 → diff=0xFFFF_FFFF_FFFF_FFFF, borrow=1, zero=0. Then op=1 with the same operands → diff=1, borrow=0.
- a=b=0xDEAD_BEEF_CAFE_F00D → diff=0, zero=1, borrow=0.
- Hold out_ready=0 for 3 cycles in DONE with in_valid=1 → out_valid, diff and flags stay stable, in_ready=0.
  - Then pulse out_ready → IDLE next cycle, and the next operand is accepted one cycle later.
- Assert rst asynchronously after 2 RUN cycles → out_valid=0 and in_ready=1 immediately.
  - No result is emitted.
  - A fresh operation of 7-9 then gives diff=0xFFFF_FFFF_FFFF_FFFE, borrow=1.
